// File: rtl/rv32_bus_arbiter_pkg.sv
// Shared types and constants for the instruction/data bus arbiter.
// Guarded against repeated inclusion.
`ifndef RV32_BUS_ARBITER_PKG_SV
`define RV32_BUS_ARBITER_PKG_SV
package rv32_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_BUSY_INSTR = 2'd1,
    ST_BUSY_DATA  = 2'd2
  } arb_state_e;

  localparam logic REQ_INSTR = 1'b0;
  localparam logic REQ_DATA  = 1'b1;

  localparam int MASK_W = 4;

endpackage
`endif

// File: rtl/rv32_bus_arbiter_if.sv
// Requester and memory-bus signals of the arbiter; slave = arbiter side,
// master = requesters plus memory (the environment around the arbiter).
interface rv32_bus_arbiter_if;
  // Handshake: a requester holds its read/write high with stable address and
  // data until it sees its ready pulse; the bus completes a transaction by
  // raising bus_ready_in for one cycle while the strobes are up.
  logic                                    instr_read_in;
  logic [31:0]                             instr_address_in;
  logic                                    instr_ready_out;
  logic [31:0]                             instr_read_value_out;
  logic                                    data_read_in;
  logic                                    data_write_in;
  logic [31:0]                             data_address_in;
  logic [rv32_bus_arbiter_pkg::MASK_W-1:0] data_write_mask_in;
  logic [31:0]                             data_write_value_in;
  logic                                    data_ready_out;
  logic [31:0]                             data_read_value_out;
  logic [31:0]                             bus_address_out;
  logic                                    bus_read_out;
  logic                                    bus_write_out;
  logic [rv32_bus_arbiter_pkg::MASK_W-1:0] bus_write_mask_out;
  logic [31:0]                             bus_write_value_out;
  logic [31:0]                             bus_read_value_in;
  logic                                    bus_ready_in;

  modport slave (
    input  instr_read_in, instr_address_in,
    output instr_ready_out, instr_read_value_out,
    input  data_read_in, data_write_in, data_address_in,
    input  data_write_mask_in, data_write_value_in,
    output data_ready_out, data_read_value_out,
    output bus_address_out, bus_read_out, bus_write_out,
    output bus_write_mask_out, bus_write_value_out,
    input  bus_read_value_in, bus_ready_in
  );

  modport master (
    output instr_read_in, instr_address_in,
    input  instr_ready_out, instr_read_value_out,
    output data_read_in, data_write_in, data_address_in,
    output data_write_mask_in, data_write_value_in,
    input  data_ready_out, data_read_value_out,
    input  bus_address_out, bus_read_out, bus_write_out,
    input  bus_write_mask_out, bus_write_value_out,
    output bus_read_value_in, bus_ready_in
  );
endinterface

// File: rtl/rv32_bus_arbiter_watchdog.sv
// Bus watchdog: counts busy cycles without bus_ready and flags an abort when
// the limit is reached; TIMEOUT_CYCLES = 0 disables it.
module rv32_bus_arbiter_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic busy_i,
  input  logic bus_ready_i,
  output logic expire_o,
  output logic timeout_o
);
  localparam logic [31:0] LIMIT = 32'(TIMEOUT_CYCLES);

  logic [31:0] count_q, count_d;
  logic        timeout_q;

  // A completing bus_ready in the limit cycle wins over the abort.
  assign expire_o  = (LIMIT != 32'd0) && busy_i && !bus_ready_i && (count_q == LIMIT);
  assign timeout_o = timeout_q;

  always_comb begin
    count_d = count_q;
    if (!busy_i || bus_ready_i || expire_o) begin
      count_d = '0;
    end else if (LIMIT != 32'd0) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (expire_o) timeout_q <= 1'b1;
    end
  end
endmodule

// File: rtl/rv32_bus_arbiter.sv
// Shares one memory bus between instruction fetch and load/store.
// Optional RV32_BUS_ARB_ROUND_ROBIN_EN: alternate grants when both request.
module rv32_bus_arbiter
  import rv32_bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  rv32_bus_arbiter_if.slave   bus_if,
  output logic                timeout_out,
  output arb_state_e          arb_state_o
);
  arb_state_e          state_q;
  logic [31:0]         addr_q;
  logic                rd_q;
  logic                wr_q;
  logic [MASK_W-1:0]   mask_q;
  logic [31:0]         wval_q;

  logic instr_req, data_req, grant_data, busy, expire, finish;

  assign instr_req = bus_if.instr_read_in;
  assign data_req  = bus_if.data_read_in | bus_if.data_write_in;

`ifdef RV32_BUS_ARB_ROUND_ROBIN_EN
  logic last_grant_q;
  assign grant_data = data_req && (!instr_req || (last_grant_q == REQ_INSTR));
`else
  // Data is the older instruction in the pipe, so it must win to avoid deadlock.
  assign grant_data = data_req;
`endif

  // A reset cycle abandons the transaction without a ready pulse.
  assign busy   = (state_q != ST_IDLE) && !reset;
  assign finish = busy && (bus_if.bus_ready_in || expire);

  rv32_bus_arbiter_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk         (clk),
    .reset       (reset),
    .busy_i      (busy),
    .bus_ready_i (bus_if.bus_ready_in),
    .expire_o    (expire),
    .timeout_o   (timeout_out)
  );

  assign bus_if.instr_ready_out = finish && (state_q == ST_BUSY_INSTR);
  assign bus_if.data_ready_out  = finish && (state_q == ST_BUSY_DATA);
  assign bus_if.instr_read_value_out =
    (busy && state_q == ST_BUSY_INSTR && bus_if.bus_ready_in) ? bus_if.bus_read_value_in : 32'd0;
  assign bus_if.data_read_value_out =
    (busy && state_q == ST_BUSY_DATA && bus_if.bus_ready_in) ? bus_if.bus_read_value_in : 32'd0;

  assign bus_if.bus_address_out     = addr_q;
  assign bus_if.bus_read_out        = rd_q;
  assign bus_if.bus_write_out       = wr_q;
  assign bus_if.bus_write_mask_out  = mask_q;
  assign bus_if.bus_write_value_out = wval_q;
  assign arb_state_o                = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      mask_q  <= '0;
      wval_q  <= '0;
`ifdef RV32_BUS_ARB_ROUND_ROBIN_EN
      last_grant_q <= REQ_INSTR;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_data) begin
            addr_q  <= bus_if.data_address_in;
            wr_q    <= bus_if.data_write_in;
            rd_q    <= bus_if.data_read_in & ~bus_if.data_write_in;
            mask_q  <= bus_if.data_write_mask_in;
            wval_q  <= bus_if.data_write_value_in;
            state_q <= ST_BUSY_DATA;
`ifdef RV32_BUS_ARB_ROUND_ROBIN_EN
            last_grant_q <= REQ_DATA;
`endif
          end else if (instr_req) begin
            addr_q  <= bus_if.instr_address_in;
            rd_q    <= 1'b1;
            wr_q    <= 1'b0;
            mask_q  <= '0;
            wval_q  <= '0;
            state_q <= ST_BUSY_INSTR;
`ifdef RV32_BUS_ARB_ROUND_ROBIN_EN
            last_grant_q <= REQ_INSTR;
`endif
          end else begin
            rd_q <= 1'b0;
            wr_q <= 1'b0;
          end
        end
        ST_BUSY_INSTR, ST_BUSY_DATA: begin
          if (finish) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          rd_q    <= 1'b0;
          wr_q    <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rv32_bus_arbiter.sv
// Directed bench for rv32_bus_arbiter (watchdog limit 4); expectations are
// hand-computed per step. Honours RV32_BUS_ARB_ROUND_ROBIN_EN.
module tb_rv32_bus_arbiter;
  import rv32_bus_arbiter_pkg::*;

  logic       clk;
  logic       reset;
  logic       timeout_out;
  arb_state_e arb_state;
  int         n_assert = 0;
  int         n_fail   = 0;

  rv32_bus_arbiter_if bus_if ();

  rv32_bus_arbiter #(
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus_if      (bus_if.slave),
    .timeout_out (timeout_out),
    .arb_state_o (arb_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  // Driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.instr_read_in       = 1'b0;
    bus_if.instr_address_in    = 32'd0;
    bus_if.data_read_in        = 1'b0;
    bus_if.data_write_in       = 1'b0;
    bus_if.data_address_in     = 32'd0;
    bus_if.data_write_mask_in  = 4'd0;
    bus_if.data_write_value_in = 32'd0;
    bus_if.bus_read_value_in   = 32'd0;
    bus_if.bus_ready_in        = 1'b0;
  endtask

  // Scoreboard check
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [31:0] exp_q[$];

  initial begin
    idle_inputs();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    #1;
    chk("rst_state", 32'(arb_state), 32'(ST_IDLE));
    chk("rst_addr", bus_if.bus_address_out, 32'd0);
    chk("rst_rd", 32'(bus_if.bus_read_out), 32'd0);
    chk("rst_wr", 32'(bus_if.bus_write_out), 32'd0);
    chk("rst_mask", 32'(bus_if.bus_write_mask_out), 32'd0);
    chk("rst_wval", bus_if.bus_write_value_out, 32'd0);
    chk("rst_irdy", 32'(bus_if.instr_ready_out), 32'd0);
    chk("rst_drdy", 32'(bus_if.data_ready_out), 32'd0);
    chk("rst_ival", bus_if.instr_read_value_out, 32'd0);
    chk("rst_dval", bus_if.data_read_value_out, 32'd0);
    chk("rst_tmo", 32'(timeout_out), 32'd0);

    // 1: instr read, bus ready one cycle after the strobe
    bus_if.instr_read_in = 1'b1;
    bus_if.instr_address_in = 32'h100;
    cyc();
    #1;
    chk("t1_state", 32'(arb_state), 32'(ST_BUSY_INSTR));
    chk("t1_rd", 32'(bus_if.bus_read_out), 32'd1);
    chk("t1_wr", 32'(bus_if.bus_write_out), 32'd0);
    chk("t1_addr", bus_if.bus_address_out, 32'h100);
    chk("t1_irdy_early", 32'(bus_if.instr_ready_out), 32'd0);
    cyc();
    bus_if.bus_ready_in = 1'b1;
    bus_if.bus_read_value_in = 32'hDEADBEEF;
    #1;
    chk("t1_irdy", 32'(bus_if.instr_ready_out), 32'd1);
    chk("t1_ival", bus_if.instr_read_value_out, 32'hDEADBEEF);
    chk("t1_drdy", 32'(bus_if.data_ready_out), 32'd0);
    cyc();
    idle_inputs();
    #1;
    chk("t1_idle", 32'(arb_state), 32'(ST_IDLE));
    chk("t1_rd_off", 32'(bus_if.bus_read_out), 32'd0);
    chk("t1_irdy_off", 32'(bus_if.instr_ready_out), 32'd0);

    // 2: simultaneous requests, data first
    bus_if.instr_read_in = 1'b1;
    bus_if.instr_address_in = 32'h104;
    bus_if.data_read_in = 1'b1;
    bus_if.data_address_in = 32'h2000;
    cyc();
    #1;
    chk("t2_state", 32'(arb_state), 32'(ST_BUSY_DATA));
    chk("t2_addr", bus_if.bus_address_out, 32'h2000);
    chk("t2_irdy_own", 32'(bus_if.instr_ready_out), 32'd0);
    bus_if.bus_ready_in = 1'b1;
    bus_if.bus_read_value_in = 32'hCAFEF00D;
    #1;
    chk("t2_drdy", 32'(bus_if.data_ready_out), 32'd1);
    chk("t2_dval", bus_if.data_read_value_out, 32'hCAFEF00D);
    chk("t2_irdy_hold", 32'(bus_if.instr_ready_out), 32'd0);
    chk("t2_ival_hold", bus_if.instr_read_value_out, 32'd0);
    cyc();
    bus_if.data_read_in = 1'b0;
    bus_if.bus_ready_in = 1'b0;
    #1;
    chk("t2_idle", 32'(arb_state), 32'(ST_IDLE));
    chk("t2_irdy_idle", 32'(bus_if.instr_ready_out), 32'd0);
    cyc();
    #1;
    chk("t2_istate", 32'(arb_state), 32'(ST_BUSY_INSTR));
    chk("t2_iaddr", bus_if.bus_address_out, 32'h104);
    bus_if.bus_ready_in = 1'b1;
    bus_if.bus_read_value_in = 32'h11112222;
    #1;
    chk("t2_irdy", 32'(bus_if.instr_ready_out), 32'd1);
    chk("t2_ival", bus_if.instr_read_value_out, 32'h11112222);
    cyc();
    idle_inputs();

    // 3: store with read+write high, held until ready
    bus_if.data_read_in = 1'b1;
    bus_if.data_write_in = 1'b1;
    bus_if.data_address_in = 32'h40;
    bus_if.data_write_mask_in = 4'b0011;
    bus_if.data_write_value_in = 32'h12345678;
    cyc();
    #1;
    chk("t3_wr", 32'(bus_if.bus_write_out), 32'd1);
    chk("t3_rd", 32'(bus_if.bus_read_out), 32'd0);
    chk("t3_addr", bus_if.bus_address_out, 32'h40);
    chk("t3_mask", 32'(bus_if.bus_write_mask_out), 32'h3);
    chk("t3_wval", bus_if.bus_write_value_out, 32'h12345678);
    chk("t3_drdy_wait", 32'(bus_if.data_ready_out), 32'd0);
    cyc();
    #1;
    chk("t3_mask_hold", 32'(bus_if.bus_write_mask_out), 32'h3);
    chk("t3_wval_hold", bus_if.bus_write_value_out, 32'h12345678);
    bus_if.bus_ready_in = 1'b1;
    bus_if.bus_read_value_in = 32'hAAAA5555;
    #1;
    chk("t3_drdy", 32'(bus_if.data_ready_out), 32'd1);
    chk("t3_dval", bus_if.data_read_value_out, 32'hAAAA5555);
    cyc();
    idle_inputs();
    #1;
    chk("t3_drdy_pulse", 32'(bus_if.data_ready_out), 32'd0);
    chk("t3_wr_off", 32'(bus_if.bus_write_out), 32'd0);

    // 3b: zero-mask write still reaches the bus
    bus_if.data_write_in = 1'b1;
    bus_if.data_address_in = 32'h44;
    cyc();
    #1;
    chk("t3b_wr", 32'(bus_if.bus_write_out), 32'd1);
    chk("t3b_mask", 32'(bus_if.bus_write_mask_out), 32'h0);
    bus_if.bus_ready_in = 1'b1;
    cyc();
    idle_inputs();

    // 4a: bus_ready exactly at the watchdog limit completes normally
    bus_if.data_read_in = 1'b1;
    bus_if.data_address_in = 32'h80;
    cyc();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t4a_drdy_wait", 32'(bus_if.data_ready_out), 32'd0);
      cyc();
    end
    bus_if.bus_ready_in = 1'b1;
    bus_if.bus_read_value_in = 32'h0BADF00D;
    #1;
    chk("t4a_drdy", 32'(bus_if.data_ready_out), 32'd1);
    chk("t4a_dval", bus_if.data_read_value_out, 32'h0BADF00D);
    cyc();
    idle_inputs();
    #1;
    chk("t4a_tmo", 32'(timeout_out), 32'd0);

    // 4b: bus never ready, abort after four busy cycles
    bus_if.data_read_in = 1'b1;
    bus_if.data_address_in = 32'h84;
    bus_if.bus_read_value_in = 32'h55555555;
    cyc();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t4b_drdy_wait", 32'(bus_if.data_ready_out), 32'd0);
      cyc();
    end
    #1;
    chk("t4b_drdy", 32'(bus_if.data_ready_out), 32'd1);
    chk("t4b_dval", bus_if.data_read_value_out, 32'd0);
    chk("t4b_tmo_pre", 32'(timeout_out), 32'd0);
    cyc();
    idle_inputs();
    #1;
    chk("t4b_tmo", 32'(timeout_out), 32'd1);
    chk("t4b_idle", 32'(arb_state), 32'(ST_IDLE));
    chk("t4b_rd_off", 32'(bus_if.bus_read_out), 32'd0);
    bus_if.instr_read_in = 1'b1;
    bus_if.instr_address_in = 32'h200;
    cyc();
    bus_if.bus_ready_in = 1'b1;
    bus_if.bus_read_value_in = 32'h600DCAFE;
    #1;
    chk("t4b_good_irdy", 32'(bus_if.instr_ready_out), 32'd1);
    chk("t4b_good_ival", bus_if.instr_read_value_out, 32'h600DCAFE);
    cyc();
    idle_inputs();
    #1;
    chk("t4b_tmo_sticky", 32'(timeout_out), 32'd1);

    // 5: reset while BUSY_INSTR abandons silently
    bus_if.instr_read_in = 1'b1;
    bus_if.instr_address_in = 32'h300;
    cyc();
    reset = 1'b1;
    bus_if.bus_ready_in = 1'b1;
    bus_if.bus_read_value_in = 32'h77777777;
    #1;
    chk("t5_irdy_rst", 32'(bus_if.instr_ready_out), 32'd0);
    chk("t5_ival_rst", bus_if.instr_read_value_out, 32'd0);
    cyc();
    reset = 1'b0;
    bus_if.bus_ready_in = 1'b0;
    bus_if.instr_address_in = 32'h304;
    #1;
    chk("t5_rd_off", 32'(bus_if.bus_read_out), 32'd0);
    chk("t5_tmo", 32'(timeout_out), 32'd0);
    chk("t5_idle", 32'(arb_state), 32'(ST_IDLE));
    chk("t5_irdy", 32'(bus_if.instr_ready_out), 32'd0);
    cyc();
    #1;
    chk("t5_regrant", 32'(arb_state), 32'(ST_BUSY_INSTR));
    chk("t5_addr", bus_if.bus_address_out, 32'h304);
    bus_if.bus_ready_in = 1'b1;
    bus_if.bus_read_value_in = 32'h30403040;
    #1;
    chk("t5_irdy_done", 32'(bus_if.instr_ready_out), 32'd1);
    cyc();
    idle_inputs();

    // 6: both requesters requesting continuously
`ifdef RV32_BUS_ARB_ROUND_ROBIN_EN
    exp_q = '{32'h600, 32'h700, 32'h600, 32'h700};
`else
    exp_q = '{32'h600, 32'h600, 32'h600, 32'h600};
`endif
    bus_if.instr_read_in = 1'b1;
    bus_if.instr_address_in = 32'h700;
    bus_if.data_read_in = 1'b1;
    bus_if.data_address_in = 32'h600;
    while (exp_q.size() > 0) begin
      logic [31:0] exp_addr;
      exp_addr = exp_q.pop_front();
      cyc();
      #1;
      chk("t6_addr", bus_if.bus_address_out, exp_addr);
      bus_if.bus_ready_in = 1'b1;
      #1;
      chk("t6_drdy", 32'(bus_if.data_ready_out), (exp_addr == 32'h600) ? 32'd1 : 32'd0);
      chk("t6_irdy", 32'(bus_if.instr_ready_out), (exp_addr == 32'h700) ? 32'd1 : 32'd0);
      cyc();
      bus_if.bus_ready_in = 1'b0;
    end
    idle_inputs();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
